// File: rtl/multi_channel_sample_if.sv
// multi_channel_sample_if
//   Bus bundle for the multi-channel logic-analyser sampler.
//   master : the capture controller. It drives ch_in, smpl_en, run and slide,
//            and it receives the packed history and the status pulses.
//   slave  : the sampler itself (multi_channel_sample).
//   Signals:
//     ch_in     [NUM_CH]       raw asynchronous channel inputs
//     smpl_en                  one-clk sample strobe
//     run                      capture enable
//     slide                    0 = block packets, 1 = sliding window
//     smpl      [NUM_CH*DEPTH] packed history word, newest sample in MS group
//     smpl_vld                 one-clk pulse when smpl holds a new packet
//     ch_rise   [NUM_CH]       per-channel 0->1 pulse between samples
//     ch_fall   [NUM_CH]       per-channel 1->0 pulse between samples
//     ch_oldest [NUM_CH]       oldest history stage per channel
interface multi_channel_sample_if #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
);
  logic [NUM_CH-1:0]       ch_in;
  logic                    smpl_en;
  logic                    run;
  logic                    slide;
  logic [NUM_CH*DEPTH-1:0] smpl;
  logic                    smpl_vld;
  logic [NUM_CH-1:0]       ch_rise;
  logic [NUM_CH-1:0]       ch_fall;
  logic [NUM_CH-1:0]       ch_oldest;

  modport master (
    output ch_in, smpl_en, run, slide,
    input  smpl, smpl_vld, ch_rise, ch_fall, ch_oldest
  );

  modport slave (
    input  ch_in, smpl_en, run, slide,
    output smpl, smpl_vld, ch_rise, ch_fall, ch_oldest
  );
endinterface

// File: rtl/multi_channel_sample.sv
// multi_channel_sample
//   Synchronises NUM_CH asynchronous logic-analyser inputs into clk. It keeps
//   a DEPTH-deep history per channel, which shifts on smpl_en while run is
//   high. The history is emitted as packed words with a valid pulse, in block
//   or sliding mode. The sampler also flags per-channel rising and falling
//   edges between consecutive samples.
//   Ports:
//     clk    system clock, all logic on posedge
//     rst_n  asynchronous active-low reset
//     bus    multi_channel_sample_if.slave. It carries ch_in, smpl_en, run and
//            slide into the block, and smpl, smpl_vld, ch_rise, ch_fall and
//            ch_oldest out of it.
module multi_channel_sample #(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_channel_sample_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]       sync_q   [SYNC_STAGES];
  logic [NUM_CH-1:0]       s;
  logic [NUM_CH-1:0]       hist     [DEPTH];
  logic [NUM_CH-1:0]       hist_nxt [DEPTH];
  logic [NUM_CH*DEPTH-1:0] smpl_q;
  logic [NUM_CH*DEPTH-1:0] smpl_nxt;
  logic                    vld_q;
  logic [NUM_CH-1:0]       rise_q;
  logic [NUM_CH-1:0]       fall_q;
  logic [CW-1:0]           pack_cnt;
  logic [CW-1:0]           fill_cnt;
  logic [CW-1:0]           fill_nxt;
  logic                    have_prev;
  logic                    pack_wrap;

  // Synchroniser runs every clk, independent of run/smpl_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.ch_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Next history and its packed form. The packed word is registered from
  // hist_nxt so that smpl changes on the same edge as the history.
  always_comb begin
    hist_nxt[0] = s;
    for (int unsigned d = 1; d < DEPTH; d++) hist_nxt[d] = hist[d-1];
  end

  always_comb begin
    smpl_nxt = '0;
    for (int unsigned d = 0; d < DEPTH; d++)
      for (int unsigned c = 0; c < NUM_CH; c++)
        smpl_nxt[(DEPTH-1-d)*NUM_CH + c] = hist_nxt[d][c];
  end

  assign pack_wrap = (pack_cnt == CW'(DEPTH - 1));
  assign fill_nxt  = (fill_cnt == CW'(DEPTH)) ? fill_cnt : fill_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < DEPTH; d++) hist[d] <= '0;
      smpl_q    <= '0;
      vld_q     <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
      pack_cnt  <= '0;
      fill_cnt  <= '0;
      have_prev <= 1'b0;
    end else if (!bus.run) begin
      // Idle: the history and smpl hold, and the packet state restarts.
      vld_q     <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
      pack_cnt  <= '0;
      fill_cnt  <= '0;
      have_prev <= 1'b0;
    end else if (bus.smpl_en) begin
      for (int unsigned d = 0; d < DEPTH; d++) hist[d] <= hist_nxt[d];
      smpl_q    <= smpl_nxt;
      pack_cnt  <= pack_wrap ? '0 : pack_cnt + 1'b1;
      fill_cnt  <= fill_nxt;
      have_prev <= 1'b1;
      vld_q     <= bus.slide ? (fill_nxt == CW'(DEPTH)) : pack_wrap;
      rise_q    <= have_prev ? (s & ~hist[0]) : '0;
      fall_q    <= have_prev ? (~s & hist[0]) : '0;
    end else begin
      vld_q  <= 1'b0;
      rise_q <= '0;
      fall_q <= '0;
    end
  end

  assign bus.smpl      = smpl_q;
  assign bus.smpl_vld  = vld_q;
  assign bus.ch_rise   = rise_q;
  assign bus.ch_fall   = fall_q;
  assign bus.ch_oldest = hist[DEPTH-1];

endmodule

// File: tb/tb_multi_channel_sample.sv
module tb_multi_channel_sample;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;
  localparam int W      = NUM_CH * DEPTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_channel_sample_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

  multi_channel_sample #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model. A sample taken at an edge sees the ch_in value that was
  // present SYNC edges earlier. n is the number of accepted samples since run
  // rose. The window holds the last DEPTH samples, newest first.
  logic [NUM_CH-1:0] inq[$];
  logic [NUM_CH-1:0] win[$];
  int                n;
  logic [W-1:0]      e_smpl;
  logic              e_vld;
  logic [NUM_CH-1:0] e_rise, e_fall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inq = {};
    repeat (SYNC) inq.push_back('0);
    win = {};
    repeat (DEPTH) win.push_back('0);
    n = 0; e_smpl = '0; e_vld = 0; e_rise = '0; e_fall = '0;
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = inq[inq.size() - SYNC];
    inq.push_back(bus.ch_in);
    if (inq.size() > SYNC + 2) void'(inq.pop_front());
    e_vld = 0; e_rise = '0; e_fall = '0;
    if (!bus.run) n = 0;
    else if (bus.smpl_en) begin
      n++;
      if (n >= 2) begin
        e_rise = s & ~win[0];
        e_fall = ~s & win[0];
      end
      win.push_front(s);
      void'(win.pop_back());
      e_vld = bus.slide ? (n >= DEPTH) : (n % DEPTH == 0);
      e_smpl = '0;
      for (int d = 0; d < DEPTH; d++)
        for (int c = 0; c < NUM_CH; c++)
          e_smpl[(DEPTH-1-d)*NUM_CH + c] = win[d][c];
    end
  endtask

  task automatic tick(input logic en, input logic [NUM_CH-1:0] ch,
                      input logic rn, input logic sl);
    bus.ch_in = ch; bus.smpl_en = en; bus.run = rn; bus.slide = sl;
    @(posedge clk);
    model_edge();
    #1;
    chk("smpl",      64'(bus.smpl),      64'(e_smpl));
    chk("smpl_vld",  64'(bus.smpl_vld),  64'(e_vld));
    chk("ch_rise",   64'(bus.ch_rise),   64'(e_rise));
    chk("ch_fall",   64'(bus.ch_fall),   64'(e_fall));
    chk("ch_oldest", 64'(bus.ch_oldest), 64'(win[DEPTH-1]));
  endtask

  // One sample every 4th clk with ch_in held for the whole slot.
  task automatic slot(input logic [NUM_CH-1:0] ch, input logic sl);
    repeat (3) tick(1'b0, ch, 1'b1, sl);
    tick(1'b1, ch, 1'b1, sl);
  endtask

  logic [NUM_CH-1:0] blk_vals [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  int vcount;

  initial begin
    model_reset();
    bus.ch_in = '0; bus.smpl_en = 0; bus.run = 0; bus.slide = 0;

    // Reset held with active inputs.
    for (int i = 0; i < 6; i++) tick(1'(i % 2), 2'b11, 1'b1, 1'b0);
    chk("rst_smpl_const", 64'(bus.smpl), 64'h0);
    chk("rst_oldest_const", 64'(bus.ch_oldest), 64'h0);
    #1 rst_n = 1'b1;
    repeat (3) tick(1'b0, 2'b11, 1'b1, 1'b0);
    chk("post_rst_smpl_const", 64'(bus.smpl), 64'h0);

    // Block mode.
    tick(1'b0, 2'b00, 1'b0, 1'b0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      slot(blk_vals[i], 1'b0);
      if (bus.smpl_vld) vcount++;
    end
    chk("blk_smpl_const", 64'(bus.smpl), 64'h39);
    chk("blk_oldest_const", 64'(bus.ch_oldest), 64'h1);
    chk("blk_vld_count", 64'(vcount), 64'd1);
    for (int i = 0; i < 4; i++) slot(2'(i), 1'b0);
    chk("blk_second_vld", 64'(bus.smpl_vld), 64'd1);

    // Sliding mode, with a fresh run.
    tick(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) slot(blk_vals[i], 1'b1);
    slot(2'b01, 1'b1);
    chk("slide_smpl_const", 64'(bus.smpl), 64'h4E);
    chk("slide_vld5", 64'(bus.smpl_vld), 64'd1);

    // Edges on channel 0. The first sample is 1 and must not pulse.
    tick(1'b0, 2'b00, 1'b0, 1'b0);
    slot(2'b01, 1'b0);
    chk("first_no_rise", 64'(bus.ch_rise), 64'h0);
    tick(1'b0, 2'b00, 1'b0, 1'b0);
    slot(2'b00, 1'b0); slot(2'b01, 1'b0); slot(2'b01, 1'b0); slot(2'b00, 1'b0);

    // run gating.
    tick(1'b0, 2'b00, 1'b0, 1'b0);
    slot(2'b10, 1'b0); slot(2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 2'b11, 1'b0, 1'b0);
      tick(1'b0, 2'b11, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) slot(2'b11, 1'b0);
    chk("gate_vld_after4", 64'(bus.smpl_vld), 64'd1);

    // Back-to-back sampling and latency, in sliding mode.
    tick(1'b0, 2'b00, 1'b0, 1'b1);
    repeat (6) tick(1'b1, 2'b00, 1'b1, 1'b1);
    tick(1'b1, 2'b10, 1'b1, 1'b1);
    chk("lat1", 64'(bus.smpl[W-1]), 64'd0);
    tick(1'b1, 2'b10, 1'b1, 1'b1);
    chk("lat2", 64'(bus.smpl[W-1]), 64'd0);
    tick(1'b1, 2'b10, 1'b1, 1'b1);
    chk("lat3", 64'(bus.smpl[W-1]), 64'd1);
    chk("b2b_vld", 64'(bus.smpl_vld), 64'd1);

    // Randomised traffic, including mode switches, run drops and resets.
    for (int i = 0; i < 2000; i++) begin
      logic sl;
      sl = bus.slide;
      if ($urandom_range(0, 49) == 0) sl = ~sl;
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        tick(1'b1, 2'($urandom), 1'b1, sl);
        rst_n = 1'b1;
      end
      tick(1'($urandom_range(0, 2) != 0), 2'($urandom),
           1'($urandom_range(0, 19) != 0), sl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
